// File: rtl/alu_pkg.sv
// Shared types and the golden ALU model used by alu_cmd_driver (and reusable by benches).
// The model works on up to MAX_W bits; the caller passes the active width w.
package alu_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [MAX_W-1:0] y;
        logic             zero;
        logic             carry;
    } alu_res_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction

    // Result bits above w are forced to zero so callers can compare full-width.
    function automatic alu_res_t alu_ref(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b,
                                         input logic [2:0]       op,
                                         input int unsigned      w);
        logic [MAX_W:0] mask;
        logic [MAX_W:0] am;
        logic [MAX_W:0] bm;
        logic [MAX_W:0] res;
        logic [MAX_W:0] hi;
        alu_res_t       r;
        mask = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        am   = {1'b0, a} & mask;
        bm   = {1'b0, b} & mask;
        res  = '0;
        r    = '0;
        case (op)
            OP_ADD: begin
                res     = am + bm;
                hi      = res >> w;
                r.carry = hi[0];
            end
            OP_SUB: begin
                res     = am - bm;
                r.carry = (am < bm);
            end
            OP_AND:  res = am & bm;
            OP_OR:   res = am | bm;
            OP_XOR:  res = am ^ bm;
            default: res = '0;
        endcase
        res    = res & mask;
        r.y    = res[MAX_W-1:0];
        r.zero = (res == '0);
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Command/response front end for a combinational ALU: registers operands onto the ALU,
// waits ALU_LAT cycles, samples the outputs and checks them against the golden model.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned W       = 4,
    parameter int unsigned ALU_LAT = 0,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_op,
    input  logic [W-1:0]     alu_y,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_y,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             rsp_mismatch,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] err_count
);

    state_e             state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic [W-1:0]       alu_a_q, alu_a_d;
    logic [W-1:0]       alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [W-1:0]       rsp_y_q, rsp_y_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_mm_q, rsp_mm_d;
    logic [CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    alu_res_t           gold;
    logic               mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tag_q       <= '0;
            rsp_y_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_mm_q    <= 1'b0;
            cmd_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            tag_q       <= tag_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            rsp_mm_q    <= rsp_mm_d;
            cmd_cnt_q   <= cmd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        tag_d       = tag_q;
        rsp_y_d     = rsp_y_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        rsp_mm_d    = rsp_mm_q;
        cmd_cnt_d   = cmd_cnt_q;
        err_cnt_d   = err_cnt_q;
        // Golden result is zero above bit W-1, so the full-width compare is exact.
        gold        = alu_ref(MAX_W'(alu_a_q), MAX_W'(alu_b_q), alu_op_q, W);
        mismatch    = (MAX_W'(alu_y) != gold.y) || (alu_zero != gold.zero)
                   || (alu_carry != gold.carry);
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                    tag_d     = cmd_tag;
                    if (is_legal_op(cmd_op)) begin
                        alu_a_d  = cmd_a;
                        alu_b_d  = cmd_b;
                        alu_op_d = cmd_op;
                        wait_d   = 4'(ALU_LAT);
                        state_d  = ST_EXEC;
                    end else begin
                        rsp_y_d     = '0;
                        rsp_zero_d  = 1'b0;
                        rsp_carry_d = 1'b0;
                        rsp_mm_d    = 1'b0;
                        rsp_err_d   = 1'b1;
                        err_cnt_d   = err_cnt_q + CNT_W'(1);
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    rsp_y_d     = alu_y;
                    rsp_zero_d  = alu_zero;
                    rsp_carry_d = alu_carry;
                    rsp_err_d   = 1'b0;
                    rsp_mm_d    = mismatch;
                    if (mismatch) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_tag      = tag_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_mismatch = rsp_mm_q;
    assign cmd_count    = cmd_cnt_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: two instances (ALU_LAT=0 with 16-bit counters, ALU_LAT=3 with
// 3-bit counters) driven by stub ALUs with injectable result faults.
`timescale 1ns/1ps
module tb_alu_cmd_driver;

    typedef struct {
        int a; int b; int op; int tag; int flt; int dly;
        int ey; int ez; int ec; int ee; int em;
    } vec_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     [2];
    logic       c_valid [2];
    logic       c_ready [2];
    logic [3:0] c_a     [2];
    logic [3:0] c_b     [2];
    logic [2:0] c_op    [2];
    logic [3:0] c_tag   [2];
    logic [3:0] alu_a   [2];
    logic [3:0] alu_b   [2];
    logic [2:0] alu_op  [2];
    logic [3:0] alu_y   [2];
    logic       alu_z   [2];
    logic       alu_c   [2];
    logic       r_valid [2];
    logic       r_ready [2];
    logic [3:0] r_y     [2];
    logic       r_zero  [2];
    logic       r_carry [2];
    logic [3:0] r_tag   [2];
    logic       r_err   [2];
    logic       r_mm    [2];
    logic [3:0] fault   [2];
    logic [15:0] cmd_cnt0, err_cnt0;
    logic [2:0]  cmd_cnt1, err_cnt1;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_cmd [2];
    int exp_err [2];
    int exp_aa  [2];
    int exp_ab  [2];
    int exp_aop [2];

    // Reference ALU in plain integer arithmetic: returns {carry, zero, y[3:0]}.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        int ai, bi, r;
        bit c;
        ai = int'(a);
        bi = int'(b);
        c  = 1'b0;
        case (op)
            3'd0: begin r = ai + bi; c = (r > 15); end
            3'd1: begin r = ai - bi; c = (ai < bi); end
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            default: r = 0;
        endcase
        r = ((r % 16) + 16) % 16;
        return {c, (r == 0), 4'(r)};
    endfunction

    assign {alu_c[0], alu_z[0], alu_y[0]} = model(alu_a[0], alu_b[0], alu_op[0]) ^ {2'b00, fault[0]};
    assign {alu_c[1], alu_z[1], alu_y[1]} = model(alu_a[1], alu_b[1], alu_op[1]) ^ {2'b00, fault[1]};

    alu_cmd_driver #(.W(4), .ALU_LAT(0), .TAG_W(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst[0]),
        .cmd_valid(c_valid[0]), .cmd_ready(c_ready[0]),
        .cmd_a(c_a[0]), .cmd_b(c_b[0]), .cmd_op(c_op[0]), .cmd_tag(c_tag[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
        .alu_y(alu_y[0]), .alu_zero(alu_z[0]), .alu_carry(alu_c[0]),
        .rsp_valid(r_valid[0]), .rsp_ready(r_ready[0]),
        .rsp_y(r_y[0]), .rsp_zero(r_zero[0]), .rsp_carry(r_carry[0]), .rsp_tag(r_tag[0]),
        .rsp_err(r_err[0]), .rsp_mismatch(r_mm[0]),
        .cmd_count(cmd_cnt0), .err_count(err_cnt0)
    );

    alu_cmd_driver #(.W(4), .ALU_LAT(3), .TAG_W(4), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst[1]),
        .cmd_valid(c_valid[1]), .cmd_ready(c_ready[1]),
        .cmd_a(c_a[1]), .cmd_b(c_b[1]), .cmd_op(c_op[1]), .cmd_tag(c_tag[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
        .alu_y(alu_y[1]), .alu_zero(alu_z[1]), .alu_carry(alu_c[1]),
        .rsp_valid(r_valid[1]), .rsp_ready(r_ready[1]),
        .rsp_y(r_y[1]), .rsp_zero(r_zero[1]), .rsp_carry(r_carry[1]), .rsp_tag(r_tag[1]),
        .rsp_err(r_err[1]), .rsp_mismatch(r_mm[1]),
        .cmd_count(cmd_cnt1), .err_count(err_cnt1)
    );

    function automatic int act_cmd(input int d);
        return (d == 0) ? int'(cmd_cnt0) : int'(cmd_cnt1);
    endfunction

    function automatic int act_err(input int d);
        return (d == 0) ? int'(err_cnt0) : int'(err_cnt1);
    endfunction

    function automatic int cnt_mask(input int d);
        return (d == 0) ? 32'hFFFF : 32'h7;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chk_idle_reset(input int d, input string p);
        chk({p, " cmd_ready"}, int'(c_ready[d]), 1);
        chk({p, " rsp_valid"}, int'(r_valid[d]), 0);
        chk({p, " cmd_count"}, act_cmd(d), 0);
        chk({p, " err_count"}, act_err(d), 0);
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d]     = 1'b1;
        c_valid[d] = 1'b0;
        r_ready[d] = 1'b0;
        repeat (2) @(negedge clk);
        rst[d] = 1'b0;
        chk_idle_reset(d, $sformatf("reset d%0d", d));
        chk($sformatf("reset d%0d alu_op", d), int'(alu_op[d]), 0);
        chk($sformatf("reset d%0d alu_a", d), int'(alu_a[d]), 0);
        chk($sformatf("reset d%0d rsp_y/err/mm", d),
            int'({r_y[d], r_zero[d], r_carry[d], r_err[d], r_mm[d]}), 0);
        exp_cmd[d] = 0; exp_err[d] = 0;
        exp_aa[d] = 0; exp_ab[d] = 0; exp_aop[d] = 0;
    endtask

    task automatic run_txn(input int d, input vec_t v);
        int    lat;
        string p;
        p = $sformatf("d%0d op%0d a%0d b%0d", d, v.op, v.a, v.b);
        @(negedge clk);
        chk({p, " cmd_ready"}, int'(c_ready[d]), 1);
        fault[d]   = 4'(v.flt);
        c_valid[d] = 1'b1;
        c_a[d]     = 4'(v.a);
        c_b[d]     = 4'(v.b);
        c_op[d]    = 3'(v.op);
        c_tag[d]   = 4'(v.tag);
        @(posedge clk);
        #1;
        // Keep valid high with junk while busy: it must be ignored.
        c_a[d]   = 4'($urandom);
        c_b[d]   = 4'($urandom);
        c_op[d]  = 3'($urandom);
        c_tag[d] = 4'($urandom);
        exp_cmd[d]++;
        if (v.ee != 0 || v.em != 0) exp_err[d]++;
        if (v.ee == 0) begin
            exp_aa[d] = v.a; exp_ab[d] = v.b; exp_aop[d] = v.op;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!r_valid[d] && lat < 40);
        chk({p, " latency"}, lat, (v.ee != 0) ? 1 : ((d == 0) ? 2 : 5));
        if (!r_valid[d]) begin
            c_valid[d] = 1'b0;
            return;
        end
        chk({p, " rsp_y"}, int'(r_y[d]), v.ey);
        chk({p, " rsp_zero"}, int'(r_zero[d]), v.ez);
        chk({p, " rsp_carry"}, int'(r_carry[d]), v.ec);
        chk({p, " rsp_err"}, int'(r_err[d]), v.ee);
        chk({p, " rsp_mismatch"}, int'(r_mm[d]), v.em);
        chk({p, " rsp_tag"}, int'(r_tag[d]), v.tag);
        chk({p, " alu_a/b/op"}, int'({alu_a[d], alu_b[d], alu_op[d]}),
            (exp_aa[d] << 7) | (exp_ab[d] << 3) | exp_aop[d]);
        chk({p, " cmd_count"}, act_cmd(d), exp_cmd[d] & cnt_mask(d));
        chk({p, " err_count"}, act_err(d), exp_err[d] & cnt_mask(d));
        chk({p, " cmd_ready busy"}, int'(c_ready[d]), 0);
        for (int i = 0; i < v.dly; i++) begin
            @(negedge clk);
            chk({p, " hold valid/y/ready"}, int'({r_valid[d], r_y[d], c_ready[d]}),
                (1 << 5) | (v.ey << 1));
        end
        r_ready[d] = 1'b1;
        c_valid[d] = 1'b0;
        @(posedge clk);
        #1;
        r_ready[d] = 1'b0;
        @(negedge clk);
        chk({p, " rsp_valid after hs"}, int'(r_valid[d]), 0);
        chk({p, " cmd_ready after hs"}, int'(c_ready[d]), 1);
        fault[d] = 4'd0;
    endtask

    function automatic vec_t rand_vec();
        vec_t       v;
        logic [5:0] m;
        v.a   = int'($urandom_range(0, 15));
        v.b   = int'($urandom_range(0, 15));
        v.op  = int'($urandom_range(0, 7));
        v.tag = int'($urandom_range(0, 15));
        v.flt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 0;
        v.dly = int'($urandom_range(0, 3));
        if (v.op > 4) begin
            v.ey = 0; v.ez = 0; v.ec = 0; v.ee = 1; v.em = 0;
        end else begin
            m    = model(4'(v.a), 4'(v.b), 3'(v.op));
            v.ey = int'(m[3:0]) ^ v.flt;
            v.ez = int'(m[4]);
            v.ec = int'(m[5]);
            v.ee = 0;
            v.em = (v.flt != 0) ? 1 : 0;
        end
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [10];
        vec_t v;
        bit   seen;
        //         a    b    op tag flt dly  ey   ez ec ee em
        tbl[0] = '{7,   9,   0, 1,  0,  0,   0,   1, 1, 0, 0};
        tbl[1] = '{3,   5,   1, 10, 0,  0,   14,  0, 1, 0, 0};
        tbl[2] = '{6,   3,   4, 2,  0,  0,   5,   0, 0, 0, 0};
        tbl[3] = '{1,   2,   6, 3,  0,  0,   0,   0, 0, 1, 0};
        tbl[4] = '{5,   10,  3, 4,  0,  5,   15,  0, 0, 0, 0};
        tbl[5] = '{15,  3,   2, 5,  1,  0,   2,   0, 0, 0, 1};
        tbl[6] = '{9,   9,   1, 6,  0,  1,   0,   1, 0, 0, 0};
        tbl[7] = '{15,  1,   0, 7,  0,  0,   0,   1, 1, 0, 0};
        tbl[8] = '{4,   4,   7, 8,  0,  2,   0,   0, 0, 1, 0};
        tbl[9] = '{0,   1,   1, 9,  0,  0,   15,  0, 1, 0, 0};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; c_valid[d] = 1'b0; r_ready[d] = 1'b0; fault[d] = 4'd0;
            c_a[d] = 4'd0; c_b[d] = 4'd0; c_op[d] = 3'd0; c_tag[d] = 4'd0;
        end
        do_reset(0);
        do_reset(1);

        for (int i = 0; i < 10; i++) run_txn(0, tbl[i]);
        for (int i = 0; i < 150; i++) run_txn(0, rand_vec());

        // Reset while a response is pending on the LAT=0 instance.
        @(negedge clk);
        c_valid[0] = 1'b1; c_a[0] = 4'd2; c_b[0] = 4'd2; c_op[0] = 3'd0;
        @(posedge clk);
        #1 c_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("midresp rsp_valid before reset", int'(r_valid[0]), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk_idle_reset(0, "midresp");

        // LAT=3 instance: faulty AND, then enough commands to wrap the 3-bit counters.
        v = '{15, 3, 2, 11, 1, 0, 2, 0, 0, 0, 1};
        run_txn(1, v);
        chk("d1 err_count after mismatch", act_err(1), 1);
        for (int i = 0; i < 8; i++) run_txn(1, rand_vec());
        chk("d1 cmd_count wrapped", act_cmd(1), 1);

        // Reset while the LAT=3 instance is waiting in EXEC.
        @(negedge clk);
        c_valid[1] = 1'b1; c_a[1] = 4'd1; c_b[1] = 4'd1; c_op[1] = 3'd1;
        @(posedge clk);
        #1 c_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        #1 rst[1] = 1'b0;
        @(negedge clk);
        chk_idle_reset(1, "midexec");
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (r_valid[1]) seen = 1'b1;
        end
        chk("midexec rsp_valid never rises", int'(seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
